poly_voice_alloc: RTL and testbench
===================================

Name: poly_voice_alloc

Overview:
- Polyphonic successor to the single-voice MIDI front end. Turns one tracked note into N_VOICES independent voice slots.
- Accepts parsed 3-byte MIDI events from uart_midi_rx and assigns note-ons to free slots, stealing the oldest slot when all are busy.
- Releases slots on note-off, honouring the sustain pedal.
- Presents per-voice note, velocity, gate and retrigger pulses to a bank of DDS voices.
- Runs in the 98.3 MHz audio clock domain.

Parameters:
- N_VOICES, 8, number of voice slots (2..16).
- AGE_BITS, 8, width of each slot's saturating age counter.
- MIDI_CHANNEL, 0, accepted MIDI channel (0..15).
- OMNI, 0, when 1, events on every channel are accepted.

Ports:
- clk_in  input  1  audio clock.
- rst_in  input  1  reset, asynchronous, active-low.
- event_valid_in  input  1  event strobe.
- midi_event_in  input  24  {status[23:16], data1[15:8], data2[7:0]}.
- event_ready_out  output  1  block can accept an event this cycle.
- voice_gate_out  output  N_VOICES  slot sounding (key held or sustained).
- voice_trig_out  output  N_VOICES  one-cycle pulse on (re)assignment.
- voice_note_out  output  7*N_VOICES  slot i note at [7i+6:7i].
- voice_vel_out  output  7*N_VOICES  slot i velocity at [7i+6:7i].
- voices_busy_out  output  $clog2(N_VOICES)+1  count of gated slots.

Behaviour:
- Reset (async assert, sync deassert of internal logic):
  - all gates, triggers, notes, velocities, ages and sustain state = 0;
  - event_ready_out = 1; state = IDLE.
- Acceptance: an event is taken when event_valid_in && event_ready_out. event_ready_out = 1 only in IDLE. Valid while not ready is dropped, not queued.
- Filtering: events with channel != MIDI_CHANNEL (and OMNI = 0) are consumed in 1 cycle with no state change. Status types other than 0x8n, 0x9n and 0xBn are also consumed and ignored.
- Note-on with data2 = 0 is treated as note-off.
- States:
  - IDLE: on a note-on or note-off, latch the event and go to SCAN with idx = 0. On a CC, act in the same cycle and stay in IDLE.
  - SCAN: examines slot idx per cycle, idx 0..N_VOICES-1, tracking:
    - first slot whose gate is set and note matches (match);
    - lowest-index slot with gate = 0 (free);
    - slot with maximum age, ties resolved to the lowest index (oldest).
    - After idx = N_VOICES-1, go to COMMIT.
  - COMMIT (1 cycle):
    - note-on: target = match if found, else free if found, else oldest (steal). Target gets note, velocity, gate = 1, age = 0, held = 1, trig pulse. Every other gated slot's age increments, saturating at 2^AGE_BITS-1.
    - note-off: if match is found, clear held; if sustain = 0 also clear gate. If no match, no change.
    - Return to IDLE.
- Latency: event accepted in cycle 0; outputs update at the clock edge ending cycle N_VOICES+1; event_ready_out returns high in cycle N_VOICES+2. Throughput is one note event per N_VOICES+2 cycles.
- CC handling (IDLE, 1 cycle):
  - CC64 with data2 >= 64 sets sustain.
  - CC64 with data2 < 64 clears sustain; in the same cycle, every slot with held = 0 has its gate cleared.
  - CC123 (all notes off) clears held on all slots; gates are cleared too unless sustain = 1.
  - Other CCs are ignored.
- Triggers: voice_trig_out is high for exactly one cycle, coincident with the COMMIT update; at most one bit is set per event.
- Notes and velocities persist after the gate drops, so a release envelope can continue.
- voices_busy_out is registered and updated together with the gates.
- Reset mid-SCAN aborts the event; no partial update is visible.

Test Plan:
- Reset; note-on 0x90,60,100 → after 10 cycles (N=8): slot 0 gate = 1, note = 60, vel = 100, trig[0] pulse of one cycle, busy = 1; ready low for cycles 1..9.
- Note-on for notes 60..67, then note-on 72 → slot 0 (oldest, age 7) is stolen: note = 72, trig[0] pulse, all 8 gates still set.
- Note-on 60, then note-off 0x80,60,0 → gate[0] = 0, note[0] stays 60. Repeat using 0x90,60,0 → identical result.
- CC64 = 127, note-on 60, note-off 60 → gate[0] stays 1. Then CC64 = 0 → gate[0] = 0 in the cycle after acceptance.
- Note-on 60 twice → second event retriggers slot 0 (trig pulse, age 0); busy stays 1.
- Note-on on channel 3 with MIDI_CHANNEL = 0 → no change, ready low for 1 cycle. With OMNI = 1 the same event is assigned to slot 0.

Source files
------------

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: polyphonic voice allocator for parsed MIDI events.
// Note-ons go to a slot that already holds the same note, else the lowest
// free slot, else the oldest slot (stolen). Note-offs release the matching
// slot, and the sustain pedal (CC64) can keep it sounding. CC123 turns all
// notes off.
//
// Ports:
//   clk_in           audio clock
//   rst_in           asynchronous active-low reset
//   event_valid_in   event strobe
//   midi_event_in    {status, data1, data2}
//   event_ready_out  high when an event can be accepted (IDLE only)
//   voice_gate_out   per-slot gate (key held or sustained)
//   voice_trig_out   per-slot one-cycle pulse on (re)assignment
//   voice_note_out   slot i note at [7i+6:7i]
//   voice_vel_out    slot i velocity at [7i+6:7i]
//   voices_busy_out  number of gated slots
//
// Handshake: an event is consumed on a rising clk_in edge where
// event_valid_in and event_ready_out are both high. A valid that arrives
// while ready is low is dropped, not queued.
module poly_voice_alloc #(
  parameter int N_VOICES     = 8,
  parameter int AGE_BITS     = 8,
  parameter int MIDI_CHANNEL = 0,
  parameter bit OMNI         = 1'b0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          event_valid_in,
  input  logic [23:0]                   midi_event_in,
  output logic                          event_ready_out,
  output logic [N_VOICES-1:0]           voice_gate_out,
  output logic [N_VOICES-1:0]           voice_trig_out,
  output logic [7*N_VOICES-1:0]         voice_note_out,
  output logic [7*N_VOICES-1:0]         voice_vel_out,
  output logic [$clog2(N_VOICES):0]     voices_busy_out
);
  localparam int IW = $clog2(N_VOICES);
  localparam int BW = IW + 1;
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;
  localparam logic [3:0] CHAN = 4'(MIDI_CHANNEL);

  // SKIP burns one cycle for events that are filtered out.
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, SKIP} state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [N_VOICES-1:0]  gate_q, gate_d, held_q, held_d, trig_q, trig_d;
  logic [6:0]           note_q [N_VOICES];
  logic [6:0]           note_d [N_VOICES];
  logic [6:0]           vel_q  [N_VOICES];
  logic [6:0]           vel_d  [N_VOICES];
  logic [AGE_BITS-1:0]  age_q  [N_VOICES];
  logic [AGE_BITS-1:0]  age_d  [N_VOICES];
  logic                 sus_q, sus_d;
  logic [BW-1:0]        busy_q, busy_d;

  // Latched event and scan bookkeeping.
  logic [6:0]           ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
  logic                 ev_on_q, ev_on_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 match_found_q, match_found_d, free_found_q, free_found_d;
  logic [IW-1:0]        match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [IW-1:0]        oldest_idx_q, oldest_idx_d;
  logic [AGE_BITS-1:0]  oldest_age_q, oldest_age_d;
  logic [IW-1:0]        target;

  logic [7:0] status, d1, d2;
  logic       chan_ok;

  assign status  = midi_event_in[23:16];
  assign d1      = midi_event_in[15:8];
  assign d2      = midi_event_in[7:0];
  assign chan_ok = OMNI || (status[3:0] == CHAN);

  always_comb begin
    state_d       = state_q;
    gate_d        = gate_q;
    held_d        = held_q;
    trig_d        = '0;
    note_d        = note_q;
    vel_d         = vel_q;
    age_d         = age_q;
    sus_d         = sus_q;
    ev_note_d     = ev_note_q;
    ev_vel_d      = ev_vel_q;
    ev_on_d       = ev_on_q;
    idx_d         = idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    target        = '0;

    case (state_q)
      IDLE: begin
        if (event_valid_in) begin
          if (!chan_ok) begin
            state_d = SKIP;
          end else begin
            case (status[7:4])
              4'h8, 4'h9: begin
                ev_note_d     = d1[6:0];
                ev_vel_d      = d2[6:0];
                ev_on_d       = (status[7:4] == 4'h9) && (d2 != 8'd0);
                idx_d         = '0;
                match_found_d = 1'b0;
                free_found_d  = 1'b0;
                match_idx_d   = '0;
                free_idx_d    = '0;
                oldest_idx_d  = '0;
                oldest_age_d  = '0;
                state_d       = SCAN;
              end
              4'hB: begin
                if (d1 == 8'd64) begin
                  if (d2 >= 8'd64) begin
                    sus_d = 1'b1;
                  end else begin
                    // Pedal up: anything kept alive only by sustain stops.
                    sus_d  = 1'b0;
                    gate_d = gate_q & held_q;
                  end
                end else if (d1 == 8'd123) begin
                  held_d = '0;
                  if (!sus_q) gate_d = '0;
                end
              end
              default: state_d = SKIP;
            endcase
          end
        end
      end

      SCAN: begin
        if (gate_q[idx_q] && (note_q[idx_q] == ev_note_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!gate_q[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (age_q[idx_q] > oldest_age_q) begin
          oldest_age_d = age_q[idx_q];
          oldest_idx_d = idx_q;
        end
        if (idx_q == IW'(N_VOICES - 1)) state_d = COMMIT;
        else                            idx_d   = idx_q + 1'b1;
      end

      COMMIT: begin
        if (ev_on_q) begin
          if (match_found_q)     target = match_idx_q;
          else if (free_found_q) target = free_idx_q;
          else                   target = oldest_idx_q;
          for (int i = 0; i < N_VOICES; i++) begin
            if (IW'(i) == target) begin
              note_d[i] = ev_note_q;
              vel_d[i]  = ev_vel_q;
              gate_d[i] = 1'b1;
              held_d[i] = 1'b1;
              age_d[i]  = '0;
              trig_d[i] = 1'b1;
            end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
              age_d[i] = age_q[i] + 1'b1;
            end
          end
        end else if (match_found_q) begin
          held_d[match_idx_q] = 1'b0;
          if (!sus_q) gate_d[match_idx_q] = 1'b0;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = '0;
    for (int i = 0; i < N_VOICES; i++) busy_d = busy_d + BW'(gate_d[i]);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      gate_q        <= '0;
      held_q        <= '0;
      trig_q        <= '0;
      sus_q         <= 1'b0;
      busy_q        <= '0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      ev_on_q       <= 1'b0;
      idx_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
      for (int i = 0; i < N_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      gate_q        <= gate_d;
      held_q        <= held_d;
      trig_q        <= trig_d;
      sus_q         <= sus_d;
      busy_q        <= busy_d;
      ev_note_q     <= ev_note_d;
      ev_vel_q      <= ev_vel_d;
      ev_on_q       <= ev_on_d;
      idx_q         <= idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
    end
  end

  assign event_ready_out = ready_q;
  assign voice_gate_out  = gate_q;
  assign voice_trig_out  = trig_q;
  assign voices_busy_out = busy_q;

  for (genvar g = 0; g < N_VOICES; g++) begin : g_flat
    assign voice_note_out[7*g +: 7] = note_q[g];
    assign voice_vel_out[7*g +: 7]  = vel_q[g];
  end
endmodule

// File: tb/tb_poly_voice_alloc.sv
// Testbench for poly_voice_alloc: directed scenarios followed by random
// MIDI traffic, all checked against a slot-level behavioural model.
module tb_poly_voice_alloc;
  localparam int N  = 8;
  localparam int AB = 8;
  localparam int AGE_SAT = (1 << AB) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ev_valid = 1'b0;
  logic [23:0]    ev_data = '0;
  logic           ready;
  logic [N-1:0]   gate, trig;
  logic [7*N-1:0] note_bus, vel_bus;
  logic [3:0]     busy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  poly_voice_alloc #(.N_VOICES(N), .AGE_BITS(AB), .MIDI_CHANNEL(0), .OMNI(1'b0)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .event_valid_in  (ev_valid),
    .midi_event_in   (ev_data),
    .event_ready_out (ready),
    .voice_gate_out  (gate),
    .voice_trig_out  (trig),
    .voice_note_out  (note_bus),
    .voice_vel_out   (vel_bus),
    .voices_busy_out (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_gate [N];
  bit m_held [N];
  int m_note [N];
  int m_vel  [N];
  int m_age  [N];
  bit m_sus;
  logic [N-1:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_gate[i] = 0; m_held[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
    m_sus = 0;
  endfunction

  // Applies one accepted event. low = cycles ready stays low, tgt = slot
  // that should pulse trig (-1 for none).
  function automatic void model_apply(input logic [23:0] ev, output int low, output int tgt);
    int kind, ch, a, b, m, t;
    kind = int'(ev[23:20]);
    ch   = int'(ev[19:16]);
    a    = int'(ev[15:8]);
    b    = int'(ev[7:0]);
    tgt  = -1;
    if (ch != 0) begin
      low = 1;
    end else if (kind == 8 || kind == 9) begin
      low = N + 1;
      m = -1;
      for (int i = 0; i < N; i++) if (m < 0 && m_gate[i] && m_note[i] == a) m = i;
      if (kind == 9 && b != 0) begin
        t = m;
        if (t < 0) for (int i = 0; i < N; i++) if (t < 0 && !m_gate[i]) t = i;
        if (t < 0) begin
          t = 0;
          for (int i = 1; i < N; i++) if (m_age[i] > m_age[t]) t = i;
        end
        for (int i = 0; i < N; i++) begin
          if (i == t) begin
            m_note[i] = a; m_vel[i] = b; m_gate[i] = 1; m_held[i] = 1; m_age[i] = 0;
          end else if (m_gate[i] && m_age[i] < AGE_SAT) begin
            m_age[i]++;
          end
        end
        tgt = t;
      end else if (m >= 0) begin
        m_held[m] = 0;
        if (!m_sus) m_gate[m] = 0;
      end
    end else if (kind == 'hB) begin
      low = 0;
      if (a == 64) begin
        if (b >= 64) m_sus = 1;
        else begin
          m_sus = 0;
          for (int i = 0; i < N; i++) if (!m_held[i]) m_gate[i] = 0;
        end
      end else if (a == 123) begin
        for (int i = 0; i < N; i++) begin
          m_held[i] = 0;
          if (!m_sus) m_gate[i] = 0;
        end
      end
    end else begin
      low = 1;
    end
  endfunction

  function automatic logic [N-1:0] model_gates();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_gate[i];
    return r;
  endfunction

  function automatic logic [7*N-1:0] model_notes();
    logic [7*N-1:0] r;
    for (int i = 0; i < N; i++) r[7*i +: 7] = 7'(m_note[i]);
    return r;
  endfunction

  function automatic logic [7*N-1:0] model_vels();
    logic [7*N-1:0] r;
    for (int i = 0; i < N; i++) r[7*i +: 7] = 7'(m_vel[i]);
    return r;
  endfunction

  function automatic int model_busy();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_gate[i]);
    return c;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge. Offers one event, then watches the DUT until it is
  // ready again. With poke set, a stray valid is driven while ready is low;
  // it must be dropped.
  task automatic send(input logic [23:0] ev, input bit poke);
    int low, tgt, cnt;
    logic [N-1:0] exp_trig, exp_gate;
    cnt = 0;
    while (!ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_before_event", 64'(ready), 64'd1);
    ev_valid = 1'b1;
    ev_data  = ev;
    model_apply(ev, low, tgt);
    exp_q.push_back(model_gates());
    @(negedge clk);
    ev_valid = 1'b0;
    ev_data  = 24'($urandom);
    cnt = 0;
    while (!ready && cnt < 40) begin
      check("trig_while_busy", 64'(trig), 64'd0);
      if (poke && low > 2 && cnt == 1) begin
        ev_valid = 1'b1;
        ev_data  = {8'h90, 1'b0, 7'($urandom_range(0, 127)), 8'd99};
      end else begin
        ev_valid = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    ev_valid = 1'b0;
    check("ready_low_cycles", 64'(cnt), 64'(low));
    exp_trig = '0;
    if (tgt >= 0) exp_trig[tgt] = 1'b1;
    exp_gate = exp_q.pop_front();
    check("trig", 64'(trig), 64'(exp_trig));
    check("gate", 64'(gate), 64'(exp_gate));
    check("busy", 64'(busy), 64'(model_busy()));
    check("notes", 64'(note_bus), 64'(model_notes()));
    check("vels", 64'(vel_bus), 64'(model_vels()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] ev;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_gate", 64'(gate), 64'd0);
    check("reset_trig", 64'(trig), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_notes", 64'(note_bus), 64'd0);
    check("reset_vels", 64'(vel_bus), 64'd0);

    // First note lands in slot 0.
    send(24'h903C64, 1'b0);
    check("first_note_slot0", 64'(note_bus[6:0]), 64'd60);
    check("first_vel_slot0", 64'(vel_bus[6:0]), 64'd100);

    // Fill all slots, then steal the oldest.
    for (int n = 61; n <= 67; n++) send({8'h90, 8'(n), 8'd80}, 1'b1);
    send(24'h904850, 1'b0);
    check("steal_note_slot0", 64'(note_bus[6:0]), 64'd72);
    check("steal_all_gated", 64'(gate), 64'hFF);

    // Clear, then note-off in both forms.
    send(24'hB07B00, 1'b0);
    send(24'h903C64, 1'b0);
    send(24'h803C00, 1'b0);
    check("noteoff_note_kept", 64'(note_bus[6:0]), 64'd60);
    send(24'h903C64, 1'b0);
    send(24'h903C00, 1'b0);
    check("vel0_gate_off", 64'(gate[0]), 64'd0);

    // Sustain holds the gate until the pedal is released.
    send(24'hB0407F, 1'b0);
    send(24'h903C64, 1'b0);
    send(24'h803C00, 1'b0);
    check("sustain_holds", 64'(gate[0]), 64'd1);
    send(24'hB04000, 1'b0);
    check("pedal_up_release", 64'(gate[0]), 64'd0);

    // Retrigger the same note.
    send(24'h903C64, 1'b0);
    send(24'h903C50, 1'b0);
    check("retrig_busy", 64'(busy), 64'd1);

    // Other channel, other status, other CC.
    send(24'h933E64, 1'b0);
    send(24'hE01234, 1'b0);
    send(24'hB00740, 1'b0);
    send(24'hB07B00, 1'b0);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      ev = {8'h90, 8'($urandom_range(60, 71)), 8'($urandom_range(1, 127))};
      else if (r < 65) ev = {8'h80, 8'($urandom_range(60, 71)), 8'($urandom_range(0, 127))};
      else if (r < 72) ev = {8'h90, 8'($urandom_range(60, 71)), 8'd0};
      else if (r < 82) ev = {8'hB0, 8'd64, 8'($urandom_range(0, 127))};
      else if (r < 85) ev = {8'hB0, 8'd123, 8'd0};
      else if (r < 90) ev = {8'hB0, 8'($urandom_range(0, 63)), 8'($urandom_range(0, 127))};
      else if (r < 95) ev = {4'h9, 4'($urandom_range(1, 15)), 8'($urandom_range(60, 71)), 8'd100};
      else             ev = {4'($urandom_range(10, 14)), 4'h0, 8'($urandom_range(0, 127)), 8'd5};
      send(ev, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a scan.
    ev_valid = 1'b1;
    ev_data  = 24'h904164;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midscan_rst_gate", 64'(gate), 64'd0);
    check("midscan_rst_busy", 64'(busy), 64'd0);
    check("midscan_rst_ready", 64'(ready), 64'd1);
    check("midscan_rst_notes", 64'(note_bus), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (N + 3) begin
      check("post_rst_trig", 64'(trig), 64'd0);
      @(negedge clk);
    end
    send(24'h904164, 1'b0);
    check("post_rst_slot0", 64'(note_bus[6:0]), 64'd65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
